// File: rtl/alu_rr_scheduler_pkg.sv
// Shared types and constants for the round-robin ALU scheduler: opcodes,
// FSM state encoding, operand byte slots and the watchdog default.
package alu_sched_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } alu_op_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_START,
      ST_SEND_OP,
      ST_SEND_1,
      ST_SEND_2,
      ST_SEND_3,
      ST_WAIT_RES,
      ST_CAP_LO,
      ST_RESP
   } sched_state_t;

   // Byte positions inside a requester's 24-bit {b3,b2,b1} operand word.
   localparam int SLOT_B1 = 0;
   localparam int SLOT_B2 = 1;
   localparam int SLOT_B3 = 2;

   localparam int TIMEOUT_DEFAULT = 64;

   function automatic logic [7:0] opnd_byte(input logic [23:0] opnd, input int slot);
      return opnd[slot*8 +: 8];
   endfunction

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// Requester-fabric and ALU-side signals of the scheduler; master is the
// scheduler itself, slave is the surrounding fabric plus the ALU.
interface alu_rr_scheduler_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]    req;
   logic [2*NUM_REQ-1:0]  req_op;
   logic [24*NUM_REQ-1:0] req_opnd;
   logic [NUM_REQ-1:0]    gnt;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [15:0]           rsp_data;
   logic                  rsp_err;
   logic                  busy;
   logic                  alu_start;
   logic [7:0]            alu_inbus;
   logic [7:0]            alu_outbus;
   logic                  alu_finish;

   modport master (
      input  req, req_op, req_opnd, alu_outbus, alu_finish,
      output gnt, rsp_valid, rsp_data, rsp_err, busy, alu_start, alu_inbus
   );

   modport slave (
      output req, req_op, req_opnd, alu_outbus, alu_finish,
      input  gnt, rsp_valid, rsp_data, rsp_err, busy, alu_start, alu_inbus
   );
endinterface

// File: rtl/alu_rr_scheduler_arbiter.sv
// Combinational round-robin priority search: first set req bit at or above
// ptr, wrapping; returns a one-hot grant and its index.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PW-1:0]      ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [PW-1:0]      grant_idx
);

   logic          found;
   logic [PW-1:0] idx_v;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx_v     = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         idx_v = PW'((int'(ptr) + off) % NUM_REQ);
         if (!found && req[idx_v]) begin
            found        = 1'b1;
            grant[idx_v] = 1'b1;
            grant_idx    = idx_v;
         end
      end
   end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one serial 8-bit ALU among NUM_REQ requesters.
// Optional WAIT_RES watchdog enabled by defining ALU_SCHED_TIMEOUT_EN.
module alu_rr_scheduler
   import alu_sched_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input logic                   clk,
   input logic                   rst_n,
   alu_rr_scheduler_if.master    bus
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   sched_state_t         state_reg, state_next;
   logic [NUM_REQ-1:0]   gnt_reg;
   logic [PW-1:0]        gnt_idx_reg;
   logic [PW-1:0]        ptr_reg;
   logic [PW-1:0]        ptr_next;
   logic [1:0]           op_reg;
   logic [23:0]          opnd_reg;
   logic [7:0]           hi_reg;
   logic [7:0]           lo_reg;
   logic                 err_reg;

   logic [NUM_REQ-1:0]   arb_grant;
   logic [PW-1:0]        arb_idx;
   logic                 any_req;
   logic                 timeout_hit;

   logic [1:0]           op_masked   [NUM_REQ];
   logic [23:0]          opnd_masked [NUM_REQ];
   logic [1:0]           sel_op;
   logic [23:0]          sel_opnd;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PW      (PW)
   ) u_arb (
      .req       (bus.req),
      .ptr       (ptr_reg),
      .grant     (arb_grant),
      .grant_idx (arb_idx)
   );

   assign any_req = |bus.req;

   // One-hot grant masks each requester's command; OR-reduce picks the winner.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sel
      assign op_masked[gi]   = arb_grant[gi] ? bus.req_op[2*gi +: 2]    : 2'b00;
      assign opnd_masked[gi] = arb_grant[gi] ? bus.req_opnd[24*gi +: 24] : 24'h0;
   end

   always_comb begin
      sel_op   = '0;
      sel_opnd = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_op   = sel_op | op_masked[i];
         sel_opnd = sel_opnd | opnd_masked[i];
      end
   end

   assign ptr_next = (gnt_idx_reg == PW'(NUM_REQ - 1)) ? '0 : gnt_idx_reg + PW'(1);

`ifdef ALU_SCHED_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt_reg;

   // Counts cycles spent in WAIT_RES; zero on every entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_reg <= '0;
      end else if (state_reg != ST_WAIT_RES) begin
         wait_cnt_reg <= '0;
      end else begin
         wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
      end
   end

   assign timeout_hit = (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout_hit        = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      bus.alu_start = 1'b0;
      bus.alu_inbus = 8'h00;
      bus.busy      = (state_reg != ST_IDLE);
      bus.gnt       = gnt_reg;
      bus.rsp_valid = '0;
      bus.rsp_data  = 16'h0000;
      bus.rsp_err   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (any_req) state_next = ST_START;
         end
         ST_START: begin
            bus.alu_start = 1'b1;
            state_next    = ST_SEND_OP;
         end
         ST_SEND_OP: begin
            bus.alu_inbus = {6'b000000, op_reg};
            state_next    = ST_SEND_1;
         end
         ST_SEND_1: begin
            bus.alu_inbus = opnd_byte(opnd_reg, SLOT_B1);
            state_next    = ST_SEND_2;
         end
         ST_SEND_2: begin
            bus.alu_inbus = opnd_byte(opnd_reg, SLOT_B2);
            state_next    = ST_SEND_3;
         end
         ST_SEND_3: begin
            // Only divide consumes a third operand byte (the divisor).
            if (op_reg == OP_DIV) bus.alu_inbus = opnd_byte(opnd_reg, SLOT_B3);
            state_next = ST_WAIT_RES;
         end
         ST_WAIT_RES: begin
            if (bus.alu_finish) state_next = ST_CAP_LO;
            else if (timeout_hit) state_next = ST_RESP;
         end
         ST_CAP_LO: begin
            state_next = ST_RESP;
         end
         ST_RESP: begin
            bus.rsp_valid = gnt_reg;
            bus.rsp_data  = {hi_reg, lo_reg};
            bus.rsp_err   = err_reg;
            state_next    = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Command is latched on the grant edge so requesters may drop it afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_reg     <= '0;
         gnt_idx_reg <= '0;
         ptr_reg     <= '0;
         op_reg      <= 2'b00;
         opnd_reg    <= 24'h0;
         hi_reg      <= 8'h00;
         lo_reg      <= 8'h00;
         err_reg     <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (any_req) begin
                  gnt_reg     <= arb_grant;
                  gnt_idx_reg <= arb_idx;
                  op_reg      <= sel_op;
                  opnd_reg    <= sel_opnd;
                  hi_reg      <= 8'h00;
                  lo_reg      <= 8'h00;
                  err_reg     <= 1'b0;
               end
            end
            ST_WAIT_RES: begin
               if (bus.alu_finish) begin
                  hi_reg <= bus.alu_outbus;
               end else if (timeout_hit) begin
                  hi_reg  <= 8'hFF;
                  lo_reg  <= 8'hFF;
                  err_reg <= 1'b1;
               end
            end
            ST_CAP_LO: begin
               lo_reg <= bus.alu_outbus;
               if (!bus.alu_finish) err_reg <= 1'b1;
            end
            ST_RESP: begin
               gnt_reg <= '0;
               ptr_reg <= ptr_next;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one serial 8-bit ALU control unit between NUM_REQ requesters.
- Picks a requester round-robin and drives the ALU start/INBUS byte sequence: opcode, then three operand bytes.
- Captures the two result bytes the ALU returns on OUTBUS and hands them back as one 16-bit response pulse.
- Sits between the requester fabric and the ALU. It is the only master of alu_start and alu_inbus.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 64, watchdog limit in WAIT_RES; used only with ALU_SCHED_TIMEOUT_EN

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
req  input  NUM_REQ  per-requester request level
req_op  input  2*NUM_REQ  opcode per requester (00 add, 01 sub, 10 mul, 11 div); slice i = [2i+1:2i]
req_opnd  input  24*NUM_REQ  operand bytes per requester {b3,b2,b1}; b1 = [24i+7:24i]
gnt  output  NUM_REQ  one-hot grant, held from START through RESP
rsp_valid  output  NUM_REQ  one-cycle response pulse to the granted requester
rsp_data  output  16  {hi byte, lo byte} result, valid with rsp_valid
rsp_err  output  1  timeout flag, valid with rsp_valid
busy  output  1  high in every state except IDLE
alu_start  output  1  ALU start
alu_inbus  output  8  ALU INBUS
alu_outbus  input  8  ALU OUTBUS
alu_finish  input  1  ALU finish

Behaviour:
- Reset values (async on rst_n low): state IDLE; gnt=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, alu_start=0, alu_inbus=0; rr pointer=0.
- The ALU shares rst_n, so a reset mid-transaction aborts both blocks cleanly. No response is issued for the aborted transaction.
- Arbitration: in IDLE, if any req bit is set, grant the first set bit searching upward from ptr, wrapping.
  - gnt is registered and becomes valid in START.
  - The selected opcode and operands are latched into internal registers on the grant edge; requesters need not hold them afterwards.
  - ptr = granted index + 1 (mod NUM_REQ), updated in RESP.
- States and sequencing (one cycle each unless noted):
  - IDLE: no request -> stay; request -> START.
  - START: alu_start=1, alu_inbus=0.
  - SEND_OP: alu_inbus={6'b0,op}.
  - SEND_1: alu_inbus=b1 (add/sub/div: A or dividend high; mul: multiplier).
  - SEND_2: alu_inbus=b2 (add/sub/mul: M; div: dividend low).
  - SEND_3: alu_inbus=b3 (div: divisor; otherwise driven 0).
  - WAIT_RES: alu_inbus=0; stays until alu_finish=1, then captures alu_outbus as hi byte -> CAP_LO.
  - CAP_LO: captures alu_outbus as lo byte. If alu_finish is not high in this cycle, set rsp_err=1 (protocol error). -> RESP.
  - RESP: rsp_valid[gnt]=1, rsp_data={hi,lo}; then clear gnt -> IDLE.
- alu_start is asserted only in START. It is never asserted while busy from a previous transaction.
- Latency for add/sub: alu_finish arrives 6 cycles after START, RESP is 8 cycles after START, and the next START can follow 2 cycles after RESP (IDLE, START). Mul/div latency is data-independent but longer; the scheduler never counts it and keys only on alu_finish.
- Boundary cases:
  - req dropped after grant: the transaction still completes and rsp_valid still pulses.
  - Requester re-asserts req in the RESP cycle: it is arbitrated normally in the next IDLE, and the rr pointer gives the others priority first.
  - All req set continuously: grants cycle 0,1,..,NUM_REQ-1,0.
  - A single requester can be granted back-to-back.
  - alu_finish high outside WAIT_RES/CAP_LO: ignored.

Optional Feature:
- ALU_SCHED_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT_RES, cleared on entry.
  - If it reaches TIMEOUT_CYCLES without alu_finish, go to RESP with rsp_data=16'hFFFF and rsp_err=1.
- Not defined: no counter; WAIT_RES waits indefinitely. rsp_err is asserted only for the CAP_LO protocol error.

Decomposition:
- Package alu_sched_pkg holds:
  - opcode constants ADD/SUB/MUL/DIV;
  - state encoding IDLE..RESP;
  - byte-slot index constants;
  - TIMEOUT default.
- Sub-module rr_arbiter (req vector and ptr in, one-hot grant out, combinational priority search) is the natural split. The pointer register stays in the top-level.

Test Plan:
- req[1]=1, op=00, b1=0x12, b2=0x34 -> alu_start in START; alu_inbus sequence 0x00, 0x00, 0x12, 0x34, 0x00; rsp_valid[1] 8 cycles after START; rsp_data=16'h4600.
- req[0], op=10, b1=0x05, b2=0x03, with ALU model -> rsp_data=16'h000F, rsp_err=0.
- req[2], op=11, b1=0x00, b2=0x64, b3=0x07 -> rsp_data=16'h020E (remainder 2, quotient 14).
- req=4'b1111 held continuously -> grants in order 0,1,2,3,0; each gnt one-hot; never two rsp_valid bits set.
- rst_n pulsed low during SEND_2 -> all outputs 0 immediately; no rsp_valid; next request restarts from ptr=0.
- With ALU_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, alu_finish stuck at 0 -> rsp_valid exactly 16 cycles after WAIT_RES entry, rsp_data=16'hFFFF, rsp_err=1.
